// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART_tx between two 16-bit command sources.
// Each granted command is sent as two bytes, high byte first, paced by tx_done.
module uart_tx_sched #(
   parameter int GAP_CYCLES = 0,
   parameter int GAP_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [15:0] cmd0,
   input  logic [15:0] cmd1,
   output logic [1:0]  ack,
   output logic        busy,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_GUARD = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [GAP_W-1:0] GAP_LAST = HAS_GAP ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};

   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             byte_sel_q, byte_sel_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             gap_to_idle_q, gap_to_idle_d;
   logic [15:0]      hold_q, hold_d;
   logic             gnt_id_q, gnt_id_d;
   logic [1:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             trmt_q, trmt_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             grant_s;

   // Preferred requester wins when it is asking, otherwise the other one.
   assign grant_s = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;

   // Next-state logic; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      byte_sel_d    = byte_sel_q;
      gap_cnt_d     = gap_cnt_q;
      gap_to_idle_d = gap_to_idle_q;
      hold_d        = hold_q;
      gnt_id_d      = gnt_id_q;

      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               hold_d     = grant_s ? cmd1 : cmd0;
               gnt_id_d   = grant_s;
               byte_sel_d = 1'b0;
               state_d    = S_START;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_START: state_d = S_GUARD;
         // tx_done may still show the previous byte's level here.
         S_GUARD: state_d = S_WAIT;
         S_WAIT: begin
            if (tx_done) begin
               if (!byte_sel_q) begin
                  byte_sel_d = 1'b1;
                  if (HAS_GAP) begin
                     gap_cnt_d     = {GAP_W{1'b0}};
                     gap_to_idle_d = 1'b0;
                     state_d       = S_GAP;
                  end else begin
                     state_d       = S_START;
                  end
               end else begin
                  state_d = S_FIN;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = {GAP_W{1'b0}};
               state_d   = gap_to_idle_q ? S_IDLE : S_START;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
               state_d   = S_GAP;
            end
         end
         S_FIN: begin
            rr_ptr_d = ~gnt_id_q;
            if (HAS_GAP) begin
               gap_cnt_d     = {GAP_W{1'b0}};
               gap_to_idle_d = 1'b1;
               state_d       = S_GAP;
            end else begin
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      trmt_d    = (state_d == S_START);
      busy_d    = (state_d != S_IDLE);
      tx_data_d = (state_d == S_START) ? (byte_sel_d ? hold_d[7:0] : hold_d[15:8]) : tx_data_q;
      ack_d     = (state_d == S_FIN) ? (gnt_id_d ? 2'b10 : 2'b01) : 2'b00;
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= 1'b0;
         byte_sel_q    <= 1'b0;
         gap_cnt_q     <= {GAP_W{1'b0}};
         gap_to_idle_q <= 1'b0;
         hold_q        <= 16'h0000;
         gnt_id_q      <= 1'b0;
         ack_q         <= 2'b00;
         busy_q        <= 1'b0;
         trmt_q        <= 1'b0;
         tx_data_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         byte_sel_q    <= byte_sel_d;
         gap_cnt_q     <= gap_cnt_d;
         gap_to_idle_q <= gap_to_idle_d;
         hold_q        <= hold_d;
         gnt_id_q      <= gnt_id_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
         trmt_q        <= trmt_d;
         tx_data_q     <= tx_data_d;
      end
   end

   assign ack     = ack_q;
   assign busy    = busy_q;
   assign trmt    = trmt_q;
   assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one instance with no gap, one with a 5-cycle gap,
// each paced by a behavioural UART_tx stub.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req0 = 2'b00, req5 = 2'b00;
   logic [15:0] cmd0 = 16'h0000, cmd1 = 16'h0000;
   logic [15:0] cmd5_0 = 16'h0000, cmd5_1 = 16'h0000;
   logic [1:0]  ack0, ack5;
   logic        busy0, busy5, trmt0, trmt5, done0, done5;
   logic [7:0]  txd0, txd5;

   logic        man_en = 1'b0, man_done = 1'b1;
   logic        auto_done0, auto_done5;
   int          auto_cnt0, auto_cnt5;

   int          n_tests = 0, n_fail = 0;
   logic [7:0]  byte_log[$];
   int          gap_log[$];
   int          trmt_cnt = 0, ack_cnt = 0, bad_pulse = 0, rst_viol = 0;
   logic        prev_trmt0 = 1'b0;
   logic [1:0]  prev_ack0 = 2'b00;
   logic        prev_done5 = 1'b1, counting = 1'b0;
   int          gcnt = 0;
   int          base, tc, ac;

   logic [7:0] exp_b [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11};
   logic [7:0] exp_d [4] = '{8'h55, 8'h66, 8'h24, 8'h68};

   always #5 clk = ~clk;

   uart_tx_sched #(.GAP_CYCLES(0), .GAP_W(8)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .cmd0(cmd0), .cmd1(cmd1),
      .ack(ack0), .busy(busy0), .trmt(trmt0), .tx_data(txd0), .tx_done(done0));

   uart_tx_sched #(.GAP_CYCLES(5), .GAP_W(8)) dut5 (
      .clk(clk), .rst(rst), .req(req5), .cmd0(cmd5_0), .cmd1(cmd5_1),
      .ack(ack5), .busy(busy5), .trmt(trmt5), .tx_data(txd5), .tx_done(done5));

   assign done0 = man_en ? man_done : auto_done0;
   assign done5 = auto_done5;

   // UART_tx stubs: done drops the edge after trmt, rises four edges later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         auto_done0 <= 1'b1; auto_cnt0 <= 0;
         auto_done5 <= 1'b1; auto_cnt5 <= 0;
      end else begin
         if (trmt0) begin
            auto_done0 <= 1'b0; auto_cnt0 <= 4;
         end else if (auto_cnt0 != 0) begin
            auto_cnt0 <= auto_cnt0 - 1;
            if (auto_cnt0 == 1) auto_done0 <= 1'b1;
         end
         if (trmt5) begin
            auto_done5 <= 1'b0; auto_cnt5 <= 4;
         end else if (auto_cnt5 != 0) begin
            auto_cnt5 <= auto_cnt5 - 1;
            if (auto_cnt5 == 1) auto_done5 <= 1'b1;
         end
      end
   end

   // Byte/ack log and pulse-width watch for the no-gap instance.
   always @(posedge clk) begin
      if (!rst) begin
         if (trmt0) begin
            byte_log.push_back(txd0);
            trmt_cnt <= trmt_cnt + 1;
         end
         if (ack0 != 2'b00) ack_cnt <= ack_cnt + 1;
         bad_pulse <= bad_pulse + ((trmt0 && prev_trmt0) ? 1 : 0)
                                + (((ack0 != 2'b00) && (prev_ack0 != 2'b00)) ? 1 : 0);
      end else begin
         rst_viol <= rst_viol + ((trmt0 || busy0 || (ack0 != 2'b00)) ? 1 : 0);
      end
      prev_trmt0 <= trmt0;
      prev_ack0  <= ack0;
   end

   // Busy, non-ack cycles from tx_done rise to the next trmt on the gapped instance.
   always @(posedge clk) begin
      prev_done5 <= done5;
      if (rst) begin
         counting <= 1'b0; gcnt <= 0;
      end else if (done5 && !prev_done5) begin
         counting <= 1'b1; gcnt <= 0;
      end else if (counting) begin
         if (trmt5) begin
            gap_log.push_back(gcnt);
            counting <= 1'b0;
         end else if (busy5 && (ack5 == 2'b00)) begin
            gcnt <= gcnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input int which, input logic [1:0] exp, input string tag);
      logic [1:0] a;
      a = 2'b00;
      for (int i = 0; i < 300 && a == 2'b00; i++) begin
         @(negedge clk);
         a = (which != 0) ? ack5 : ack0;
      end
      check(tag, {30'd0, a}, {30'd0, exp});
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst ack", {30'd0, ack0}, 32'd0);
      check("rst busy", {31'd0, busy0}, 32'd0);
      check("rst trmt", {31'd0, trmt0}, 32'd0);
      check("rst tx_data", {24'd0, txd0}, 32'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle tx_done ignored", {31'd0, busy0}, 32'd0);

      // A: single command A55A
      base = byte_log.size(); tc = trmt_cnt;
      cmd0 = 16'hA55A; req0 = 2'b01;
      @(negedge clk);
      check("A trmt latency", {31'd0, trmt0}, 32'd1);
      check("A first byte", {24'd0, txd0}, 32'hA5);
      wait_ack(0, 2'b01, "A ack");
      req0 = 2'b00;
      @(negedge clk);
      check("A ack one cycle", {30'd0, ack0}, 32'd0);
      check("A busy after ack", {31'd0, busy0}, 32'd0);
      check("A trmt count", trmt_cnt - tc, 32'd2);
      check("A byte0", {24'd0, byte_log[base]}, 32'hA5);
      check("A byte1", {24'd0, byte_log[base+1]}, 32'h5A);

      // B: contention from reset, requests held
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      base = byte_log.size();
      cmd0 = 16'h1111; cmd1 = 16'h2222; req0 = 2'b11;
      wait_ack(0, 2'b01, "B ack1");
      wait_ack(0, 2'b10, "B ack2");
      wait_ack(0, 2'b01, "B ack3");
      req0 = 2'b00;
      repeat (2) @(negedge clk);
      check("B byte count", byte_log.size() - base, 32'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("B byte%0d", i), {24'd0, byte_log[base+i]}, {24'd0, exp_b[i]});

      // C: stale tx_done across GUARD, and cmd change after grant
      man_en = 1'b1; man_done = 1'b1;
      @(negedge clk);
      base = byte_log.size(); tc = trmt_cnt;
      cmd0 = 16'hBEEF; req0 = 2'b01;
      @(negedge clk);
      check("C trmt1", {31'd0, trmt0}, 32'd1);
      check("C byte hi", {24'd0, txd0}, 32'hBE);
      cmd0 = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      man_done = 1'b0;
      repeat (4) @(negedge clk);
      check("C no early trmt", trmt_cnt - tc, 32'd1);
      man_done = 1'b1;
      @(negedge clk);
      check("C trmt2", {31'd0, trmt0}, 32'd1);
      check("C byte lo", {24'd0, txd0}, 32'hEF);
      @(negedge clk);
      @(negedge clk);
      man_done = 1'b0;
      repeat (2) @(negedge clk);
      man_done = 1'b1;
      wait_ack(0, 2'b01, "C ack");
      req0 = 2'b00;
      @(negedge clk);
      man_en = 1'b0;
      check("C byte count", byte_log.size() - base, 32'd2);

      // D: reset during WAIT of the first byte
      cmd0 = 16'h1357; req0 = 2'b01;
      @(negedge clk);
      check("D trmt", {31'd0, trmt0}, 32'd1);
      repeat (3) @(negedge clk);
      ac = ack_cnt;
      rst = 1'b1;
      #1;
      check("D rst trmt", {31'd0, trmt0}, 32'd0);
      check("D rst busy", {31'd0, busy0}, 32'd0);
      check("D rst ack", {30'd0, ack0}, 32'd0);
      req0 = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("D outputs during rst", rst_viol, 32'd0);
      check("D no partial ack", ack_cnt - ac, 32'd0);
      base = byte_log.size();
      cmd0 = 16'h5566; cmd1 = 16'h2468; req0 = 2'b11;
      @(negedge clk);
      check("D rr_ptr reset", {24'd0, txd0}, 32'h55);
      wait_ack(0, 2'b01, "D ack0");
      req0 = 2'b10;
      wait_ack(0, 2'b10, "D ack1");
      req0 = 2'b00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("D byte%0d", i), {24'd0, byte_log[base+i]}, {24'd0, exp_d[i]});

      // E: GAP_CYCLES=5 instance, inter-byte and inter-command spacing
      cmd5_0 = 16'hC001; cmd5_1 = 16'hD002; req5 = 2'b11;
      wait_ack(1, 2'b01, "E ack0");
      req5 = 2'b10;
      wait_ack(1, 2'b10, "E ack1");
      req5 = 2'b00;
      repeat (10) @(negedge clk);
      check("E busy idle", {31'd0, busy5}, 32'd0);
      check("E gap count", gap_log.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("E gap%0d", i), gap_log[i], 32'd5);

      check("pulse widths", bad_pulse, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART_tx transmitter between two requesters.
- Each requester posts a 16-bit command word. The block serialises it as two bytes (high byte first), driving trmt/tx_data and pacing on tx_done.
- Sits between the command sources (e.g. the command/telemetry logic) and the UART_tx instance feeding the TX pin.

Parameters:
- GAP_CYCLES, default 0: idle clocks inserted between the two bytes of a command and between commands (0 = back-to-back).
- GAP_W, default 8: width of the gap counter; GAP_CYCLES must be < 2^GAP_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  2  per-requester request level; held until matching ack
- cmd0  input  16  command word of requester 0, valid while req[0]=1
- cmd1  input  16  command word of requester 1, valid while req[1]=1
- ack  output  2  one-cycle pulse: command of requester i fully transmitted
- busy  output  1  high whenever state != IDLE
- trmt  output  1  one-cycle start pulse to UART_tx
- tx_data  output  8  byte to UART_tx, registered, stable from trmt until the next trmt
- tx_done  input  1  UART_tx done level; cleared by UART_tx the edge after trmt, set at end of the stop bit

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- Reset values: ack=0, busy=0, trmt=0, tx_data=8'h00, state=IDLE, rr_ptr=0 (requester 0 favoured first), byte_sel=0, gap_cnt=0.
- States: IDLE, START, GUARD, WAIT, GAP, FIN.
- IDLE:
  - If any req bit is set, grant the requester per round-robin. rr_ptr names the preferred requester; if only one requests, it wins.
  - On grant, latch the winning cmd into a 16-bit holding register, record grant id, set byte_sel=0 → START.
  - The cmd input is sampled only at grant; later changes are ignored.
- START:
  - tx_data <= byte_sel ? hold[7:0] : hold[15:8]; trmt=1 for exactly this cycle → GUARD.
  - tx_data is registered, so it is driven in the same cycle as trmt.
- GUARD: one cycle; tx_done is ignored here (stale level from the previous byte) → WAIT.
- WAIT:
  - Stay until tx_done=1.
  - Then: if byte_sel=0, set byte_sel=1 and go to GAP (or START when GAP_CYCLES=0).
  - If byte_sel=1 → FIN.
- GAP: gap_cnt counts 0..GAP_CYCLES-1, then → START with the next byte.
- FIN:
  - ack[grant id]=1 for one cycle.
  - rr_ptr <= ~grant id (the other requester is preferred next).
  - → GAP-then-IDLE if GAP_CYCLES>0, else → IDLE.
- Requester handshake: the requester must deassert req in the cycle after ack. If req is still high in the cycle after ack, it is treated as a new request.
- Latency:
  - req rise in IDLE → trmt at most 2 cycles later (grant edge + START).
  - Last tx_done → ack in 2 cycles (WAIT edge + FIN).
- Simultaneous req[0]=req[1]=1 in IDLE: rr_ptr decides. Two consecutive back-to-back contentions must alternate 0,1,0,…
- req deasserted mid-transmission: the command still completes and ack still pulses; no abort.
- tx_done high during IDLE: ignored.
- rst asserted mid-operation: all state returns to reset values immediately. trmt must be 0 during and after reset; no partial ack. UART_tx is reset by its own reset.
- No combinational path from inputs to trmt, tx_data or ack.

Test Plan:
- req[0]=1, cmd0=16'hA55A, GAP_CYCLES=0, real UART_tx → TX shows byte 8'hA5 then 8'h5A, LSB-first, each with start/stop bits. Exactly two trmt pulses, ack=2'b01 once, busy low after ack.
- req=2'b11 held with cmd0=16'h1111, cmd1=16'h2222 from reset → byte order 11,11,22,22,11,11; acks alternate 01,10,01.
- GAP_CYCLES=5 → exactly 5 idle cycles between the tx_done-driven transition and the next trmt, for both inter-byte and inter-command gaps.
- Stub UART_tx with tx_done held 1 from before trmt → GUARD prevents a premature advance. Second trmt only after the stub drops and then re-raises tx_done.
- cmd0 changed from 16'hBEEF to 16'h0000 one cycle after grant → bytes BE, EF transmitted.
- rst pulsed while in WAIT of the first byte → trmt=0, busy=0, ack=0 throughout; rr_ptr=0. A new req[1] is then served normally.
